// File: rtl/seat_pkg.sv
// Shared seat-table types: seat state encoding, seat index and time-base widths.
package seat_pkg;

  localparam int NUM_SEATS = 32;
  localparam int TIME_W    = 11;
  localparam int SEAT_W    = 5;

  typedef logic [SEAT_W-1:0] seat_idx_t;

  typedef enum logic [1:0] {
    EMPTY    = 2'b00,
    RESERVED = 2'b01,
    AWAY     = 2'b10,
    SEATED   = 2'b11
  } seat_state_t;

endpackage

// File: rtl/seat_timer.sv
// Seat time base: wrapping W-bit counter advanced by a one-cycle tick pulse.
module seat_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         tick,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  // Natural modulo-2^W wrap; no overflow flag is wanted.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/seat_cmd.sv
// Seat command initiator: accepts UI seat ops, writes them to the seat table,
// reports done/reject from Do_Not_Seat, and keeps a local seated shadow.
module seat_cmd #(
  parameter int SEATS     = seat_pkg::NUM_SEATS,
  parameter int TIME_W    = seat_pkg::TIME_W,
  parameter int RESP_WAIT = 1
) (
  input  logic              clk_seat_cmd,
  input  logic              rst_seat_cmd,
  input  logic              tick_sec,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [4:0]        cmd_seat,
  output logic              wr_en,
  output logic [TIME_W-1:0] wr_time,
  output logic [1:0]        wr_state,
  output logic [4:0]        wr_seat,
  input  logic              Do_Not_Seat,
  output logic              done,
  output logic              reject,
  output logic [TIME_W-1:0] now_time,
  output logic [5:0]        occ_count
);

  import seat_pkg::*;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_WAIT,
    S_DONE,
    S_REJECT
  } fsm_t;

  fsm_t              state_reg, state_next;
  logic [2:0]        wait_reg, wait_next;
  logic              ready_reg;
  seat_state_t       op_reg;
  seat_idx_t         seat_reg;
  logic [TIME_W-1:0] time_reg;
  logic [5:0]        occ_reg, occ_next;
  seat_state_t       shadow [SEATS];
  logic [SEATS-1:0]  seated;
  logic              accept;

  seat_timer #(.W(TIME_W)) u_timer (
    .clk   (clk_seat_cmd),
    .srst  (rst_seat_cmd),
    .tick  (tick_sec),
    .count (now_time)
  );

  // Ready is registered so it stays low during the reset cycle itself.
  assign accept = (state_reg == S_IDLE) && cmd_valid && ready_reg;

  generate
    for (genvar gi = 0; gi < SEATS; gi++) begin : g_shadow
      seat_state_t cell_reg;

      always_ff @(posedge clk_seat_cmd) begin
        if (rst_seat_cmd) begin
          cell_reg <= EMPTY;
        end else if (state_reg == S_DONE && seat_reg == seat_idx_t'(gi)) begin
          cell_reg <= op_reg;
        end
      end

      assign shadow[gi] = cell_reg;
      assign seated[gi] = (cell_reg == SEATED);
    end
  endgenerate

  always_comb begin
    occ_next = '0;
    for (int i = 0; i < SEATS; i++) begin
      occ_next = occ_next + 6'(seated[i]);
    end
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    case (state_reg)
      S_IDLE:   if (accept) state_next = S_CHECK;
      S_CHECK: begin
        // Double-sit caught locally; the table is never touched.
        if (op_reg == SEATED && shadow[seat_reg] == SEATED) state_next = S_REJECT;
        else                                                 state_next = S_WRITE;
      end
      S_WRITE: begin
        state_next = S_WAIT;
        wait_next  = 3'(RESP_WAIT);
      end
      S_WAIT: begin
        if (wait_reg == 3'd1) state_next = Do_Not_Seat ? S_REJECT : S_DONE;
        else                  wait_next  = wait_reg - 3'd1;
      end
      S_DONE:   state_next = S_IDLE;
      S_REJECT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_seat_cmd) begin
    if (rst_seat_cmd) begin
      state_reg <= S_IDLE;
      wait_reg  <= '0;
      ready_reg <= 1'b0;
      op_reg    <= EMPTY;
      seat_reg  <= '0;
      time_reg  <= '0;
      occ_reg   <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      ready_reg <= (state_next == S_IDLE);
      occ_reg   <= occ_next;
      if (accept) begin
        op_reg   <= seat_state_t'(cmd_op);
        seat_reg <= cmd_seat;
        time_reg <= now_time;
      end
    end
  end

  assign cmd_ready = ready_reg;
  assign wr_en     = (state_reg == S_WRITE);
  assign wr_time   = time_reg;
  assign wr_state  = op_reg;
  assign wr_seat   = seat_reg;
  assign done      = (state_reg == S_DONE);
  assign reject    = (state_reg == S_REJECT);
  assign occ_count = occ_reg;

endmodule

// File: tb/tb_seat_cmd.sv
// Directed bench for seat_cmd: expected write/done/reject events are queued per
// command and matched against what the DUT emits, with occupancy and time models.
module tb_seat_cmd;

  import seat_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_sec;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_seat;
  logic        wr_en;
  logic [10:0] wr_time;
  logic [1:0]  wr_state;
  logic [4:0]  wr_seat;
  logic        dns;
  logic        done;
  logic        reject;
  logic [10:0] now_time;
  logic [5:0]  occ_count;

  seat_cmd dut (
    .clk_seat_cmd (clk),
    .rst_seat_cmd (rst),
    .tick_sec     (tick_sec),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_seat     (cmd_seat),
    .wr_en        (wr_en),
    .wr_time      (wr_time),
    .wr_state     (wr_state),
    .wr_seat      (wr_seat),
    .Do_Not_Seat  (dns),
    .done         (done),
    .reject       (reject),
    .now_time     (now_time),
    .occ_count    (occ_count)
  );

  always #5 clk = ~clk;

  // Event codes as {wr_en, done, reject}.
  localparam int EV_W = 4;
  localparam int EV_D = 2;
  localparam int EV_R = 1;

  typedef struct {
    int kind;
    int k;
    int seat;
    int state;
    int tstamp;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  fails  = 0;
  int  tmodel = 0;
  int  exp_shadow [32];

  always @(posedge clk) begin
    if (rst)           tmodel <= 0;
    else if (tick_sec) tmodel <= (tmodel + 1) % 2048;
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, expv);
    end
  endtask

  function automatic int occ_model();
    int n = 0;
    for (int i = 0; i < 32; i++) if (exp_shadow[i] == 3) n++;
    return n;
  endfunction

  // res: 0 = done, 1 = table reject (Do_Not_Seat), 2 = local double-sit reject.
  // dns_mask[k] is the Do_Not_Seat level for the k-th rising edge after issue (bit 0 = handshake edge).
  task automatic run_cmd(input logic [1:0] op, input int seat, input logic [8:0] dns_mask,
                         input logic tick_hs, input int res);
    ev_t e;
    int  kind;
    check("ready_idle", cmd_ready, 1);
    if (res != 2) begin
      e = '{kind: EV_W, k: 2, seat: seat, state: int'(op), tstamp: tmodel};
      sb.push_back(e);
    end
    e = '{kind: (res == 0) ? EV_D : EV_R, k: (res == 2) ? 2 : 4, seat: seat, state: 0, tstamp: 0};
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_seat  = 5'(seat);
    tick_sec  = tick_hs;
    dns       = dns_mask[0];
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("ready_drop", cmd_ready, 0);
        check("now_time", now_time, tmodel);
        cmd_valid = 1'b0;
        tick_sec  = 1'b0;
      end
      kind = {wr_en, done, reject};
      if (kind != 0) begin
        if (sb.size() == 0) begin
          check("unexpected_event", kind, 0);
        end else begin
          e = sb.pop_front();
          check("ev_kind", kind, e.kind);
          check("ev_cycle", k, e.k);
          if (e.kind == EV_W) begin
            check("wr_seat", wr_seat, e.seat);
            check("wr_state", wr_state, e.state);
            check("wr_time", wr_time, e.tstamp);
          end
        end
      end
      dns = (k < 9) ? dns_mask[k] : 1'b0;
    end
    dns = 1'b0;
    check("events_left", sb.size(), 0);
    check("ready_back", cmd_ready, 1);
    if (res == 0) exp_shadow[seat] = int'(op);
    sb.delete();
    check("occ_count", occ_count, occ_model());
    $display("cmd op=%0d seat=%0d res=%0d occ=%0d now=%0d", op, seat, res, occ_count, now_time);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 32; i++) exp_shadow[i] = 0;
    rst = 1'b1; tick_sec = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_seat = 5'd0; dns = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_wr_en", wr_en, 0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_now", now_time, 0);
    check("reset_occ", occ_count, 0);
    check("reset_ready", cmd_ready, 1);
    check("reset_wr_en", wr_en, 0);
    $display("reset done now=%0d occ=%0d ready=%0d", now_time, occ_count, cmd_ready);

    tick_sec = 1'b1;
    repeat (5) @(negedge clk);
    tick_sec = 1'b0;
    check("five_ticks", now_time, 5);
    $display("ticks now=%0d", now_time);

    run_cmd(2'b11, 7, 9'h000, 1'b0, 0);
    run_cmd(2'b11, 7, 9'h000, 1'b0, 2);
    run_cmd(2'b01, 3, 9'h008, 1'b0, 1);
    run_cmd(2'b10, 3, 9'h1F7, 1'b0, 0);
    run_cmd(2'b00, 5, 9'h000, 1'b0, 0);

    n = 2047 - tmodel;
    tick_sec = 1'b1;
    repeat (n) @(negedge clk);
    tick_sec = 1'b0;
    check("preload_2047", now_time, 2047);
    run_cmd(2'b11, 0, 9'h000, 1'b1, 0);

    // Release seat 7, interrupted by reset while waiting for the table response.
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_seat = 5'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("abort_wr_en", wr_en, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", cmd_ready, 0);
    check("abort_outputs", {wr_en, done, reject}, 0);
    check("abort_wr_regs", {wr_time, wr_state, wr_seat}, 0);
    check("abort_now", now_time, 0);
    check("abort_occ", occ_count, 0);
    for (int i = 0; i < 32; i++) exp_shadow[i] = 0;
    @(negedge clk);
    check("abort_ready_back", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_pulse", {done, reject}, 0);
    end
    $display("reset abort ready=%0d occ=%0d", cmd_ready, occ_count);

    run_cmd(2'b11, 7, 9'h000, 1'b0, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
